bsr_scan_sequencer: RTL and testbench

- On-chip sequencer for the board boundary-scan chains (SW, KEY, LED, HEX).
- Sequences one full Capture -> Shift -> Update pass on a selected chain, without an external TAP walk.
- Drives per-chain select plus shared ShiftDR/CaptureDR/UpdateDR/ScanIn toward the BSC instances, and collects ScanOut.
- Used for self-test and for firmware-driven readback/forcing of switch, key, LED and 7-segment state.

---
 rtl/bsr_scan_sequencer_if.sv | 41 ++++
 rtl/bsr_scan_sequencer.sv | 146 ++++++++++++++
 tb/tb_bsr_scan_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsr_scan_sequencer_if.sv
// Host/chain-side bundle for the boundary-scan sequencer.
// SCAN_SKIP_UPDATE_EN adds the NoUpdate request bit.
interface bsr_scan_sequencer_if #(
  parameter int DATAWIDTH = 64
);
  logic                 Start;
  logic [1:0]           ChainSel;
  logic [DATAWIDTH-1:0] WrData;
`ifdef SCAN_SKIP_UPDATE_EN
  logic                 NoUpdate;
`endif
  logic                 Busy;
  logic                 Done;
  logic [DATAWIDTH-1:0] RdData;
  logic [3:0]           Select;
  logic                 CaptureDR;
  logic                 ShiftDR;
  logic                 UpdateDR;
  logic                 ScanIn;
  logic [3:0]           ScanOut;

`ifdef SCAN_SKIP_UPDATE_EN
  modport master (
    output Start, ChainSel, WrData, NoUpdate, ScanOut,
    input  Busy, Done, RdData, Select, CaptureDR, ShiftDR, UpdateDR, ScanIn
  );
  modport slave (
    input  Start, ChainSel, WrData, NoUpdate, ScanOut,
    output Busy, Done, RdData, Select, CaptureDR, ShiftDR, UpdateDR, ScanIn
  );
`else
  modport master (
    output Start, ChainSel, WrData, ScanOut,
    input  Busy, Done, RdData, Select, CaptureDR, ShiftDR, UpdateDR, ScanIn
  );
  modport slave (
    input  Start, ChainSel, WrData, ScanOut,
    output Busy, Done, RdData, Select, CaptureDR, ShiftDR, UpdateDR, ScanIn
  );
`endif
endinterface

// File: rtl/bsr_scan_sequencer.sv
// One Capture -> Shift -> Update pass on a selected boundary-scan chain.
// Optional SCAN_SKIP_UPDATE_EN: NoUpdate latched at accept skips the UPDATE state.
module bsr_scan_sequencer #(
  parameter int LEN_SW    = 18,
  parameter int LEN_KEY   = 4,
  parameter int LEN_LED   = 27,
  parameter int LEN_HEX   = 56,
  parameter int DATAWIDTH = 64
) (
  input  logic                 TCK,
  input  logic                 Reset,
  bsr_scan_sequencer_if.slave  bus
);
  localparam int CW = $clog2(DATAWIDTH) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           chain, chain_nxt;
  logic [CW-1:0]        len, len_nxt, cnt, cnt_nxt;
  logic [DATAWIDTH-1:0] sreg, sreg_nxt, rd, rd_nxt;
  logic                 busy, done, cap, shift, upd, scan_in;
  logic [3:0]           select;
  logic                 busy_nxt, done_nxt, cap_nxt, shift_nxt, upd_nxt, scan_in_nxt;
  logic [3:0]           select_nxt;
`ifdef SCAN_SKIP_UPDATE_EN
  logic                 no_upd, no_upd_nxt;
`endif

  function automatic logic [CW-1:0] len_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return CW'(LEN_SW);
      2'd1:    return CW'(LEN_KEY);
      2'd2:    return CW'(LEN_LED);
      default: return CW'(LEN_HEX);
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    chain_nxt   = chain;
    len_nxt     = len;
    cnt_nxt     = cnt;
    sreg_nxt    = sreg;
    rd_nxt      = rd;
    scan_in_nxt = 1'b0;
`ifdef SCAN_SKIP_UPDATE_EN
    no_upd_nxt  = no_upd;
`endif
    case (state)
      IDLE: begin
        if (bus.Start) begin
          chain_nxt = bus.ChainSel;
          len_nxt   = len_of(bus.ChainSel);
          sreg_nxt  = bus.WrData;
          rd_nxt    = '0;
          cnt_nxt   = '0;
`ifdef SCAN_SKIP_UPDATE_EN
          no_upd_nxt = bus.NoUpdate;
`endif
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt   = SHIFT;
        scan_in_nxt = sreg[0];
      end
      SHIFT: begin
        // cnt is the bit index of the cycle now ending
        rd_nxt[cnt[CW-2:0]] = bus.ScanOut[chain];
        if (cnt == len - ONE) begin
`ifdef SCAN_SKIP_UPDATE_EN
          state_nxt = no_upd ? DONE : UPDATE;
`else
          state_nxt = UPDATE;
`endif
        end else begin
          cnt_nxt     = cnt + ONE;
          sreg_nxt    = sreg >> 1;
          scan_in_nxt = sreg[1];
        end
      end
      UPDATE:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = (state_nxt == DONE);
    cap_nxt    = (state_nxt == CAPTURE);
    shift_nxt  = (state_nxt == SHIFT);
    upd_nxt    = (state_nxt == UPDATE);
    select_nxt = (cap_nxt || shift_nxt || upd_nxt) ? (4'(1) << chain_nxt) : 4'd0;
  end

  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      chain   <= 2'd0;
      len     <= '0;
      cnt     <= '0;
      rd      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cap     <= 1'b0;
      shift   <= 1'b0;
      upd     <= 1'b0;
      scan_in <= 1'b0;
      select  <= 4'd0;
`ifdef SCAN_SKIP_UPDATE_EN
      no_upd  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      chain   <= chain_nxt;
      len     <= len_nxt;
      cnt     <= cnt_nxt;
      rd      <= rd_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      cap     <= cap_nxt;
      shift   <= shift_nxt;
      upd     <= upd_nxt;
      scan_in <= scan_in_nxt;
      select  <= select_nxt;
`ifdef SCAN_SKIP_UPDATE_EN
      no_upd  <= no_upd_nxt;
`endif
    end
  end

  // Outgoing data bits are only observed via scan_in, so no reset is needed here
  always_ff @(posedge TCK) begin
    sreg <= sreg_nxt;
  end

  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.RdData    = rd;
  assign bus.Select    = select;
  assign bus.CaptureDR = cap;
  assign bus.ShiftDR   = shift;
  assign bus.UpdateDR  = upd;
  assign bus.ScanIn    = scan_in;
endmodule

// File: tb/tb_bsr_scan_sequencer.sv
// Bench for bsr_scan_sequencer: four behavioural scan chains, a pass-level
// reference model checked every cycle, directed scenarios and random passes.
module tb_bsr_scan_sequencer;
  logic TCK;
  logic Reset;

  bsr_scan_sequencer_if #(.DATAWIDTH(64)) bus ();

  bsr_scan_sequencer #(
    .LEN_SW(18), .LEN_KEY(4), .LEN_LED(27), .LEN_HEX(56), .DATAWIDTH(64)
  ) dut (
    .TCK   (TCK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  int n_cmp = 0;
  int n_mis = 0;

  function automatic int len_of(input int ch);
    case (ch)
      0:       return 18;
      1:       return 4;
      2:       return 27;
      default: return 56;
    endcase
  endfunction

  function automatic logic [63:0] mask(input int n);
    if (n <= 0) return 64'd0;
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural boundary-scan chains: parallel capture value, shift register, update latch
  bit [63:0] cap_val [4];
  bit [63:0] sr      [4];
  bit [63:0] upd     [4];

  always @(posedge TCK) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.Select[i]) begin
        if (bus.CaptureDR)
          sr[i] <= cap_val[i];
        else if (bus.ShiftDR)
          sr[i] <= (sr[i] >> 1) | (64'(bus.ScanIn) << (len_of(i) - 1));
        if (bus.UpdateDR)
          upd[i] <= sr[i];
      end
    end
  end
  assign bus.ScanOut = {sr[3][0], sr[2][0], sr[1][0], sr[0][0]};

  // Pass-level reference: m_t is the cycle number since accept
  bit          m_active = 1'b0;
  int          m_t, m_len, m_ch, m_last;
  bit          m_nou;
  logic [63:0] m_wr, m_cap;
  logic [63:0] m_rd_idle = 64'd0;

  always @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      m_active  = 1'b0;
      m_rd_idle = 64'd0;
    end else if (m_active) begin
      m_t++;
      if (m_t > m_last) begin
        m_active  = 1'b0;
        m_rd_idle = m_cap & mask(m_len);
      end
    end else if (bus.Start === 1'b1) begin
      m_active  = 1'b1;
      m_t       = 1;
      m_ch      = int'(bus.ChainSel);
      m_len     = len_of(m_ch);
      m_wr      = bus.WrData;
      m_cap     = cap_val[m_ch] & mask(m_len);
`ifdef SCAN_SKIP_UPDATE_EN
      m_nou     = bus.NoUpdate;
`else
      m_nou     = 1'b0;
`endif
      m_last    = m_nou ? m_len + 2 : m_len + 3;
      m_rd_idle = 64'd0;
    end
  end

  bit          e_cap, e_sh, e_upd, e_done;
  logic [3:0]  e_sel;
  logic [63:0] e_rd;
  int          e_n;

  always @(negedge TCK) begin
    e_cap  = m_active && m_t == 1;
    e_sh   = m_active && m_t >= 2 && m_t <= m_len + 1;
    e_upd  = m_active && !m_nou && m_t == m_len + 2;
    e_done = m_active && m_t == m_last;
    e_sel  = (e_cap || e_sh || e_upd) ? (4'(1) << m_ch) : 4'd0;
    if (m_active) begin
      e_n  = (m_t - 2 < 0) ? 0 : ((m_t - 2 > m_len) ? m_len : m_t - 2);
      e_rd = m_cap & mask(e_n);
    end else begin
      e_rd = m_rd_idle;
    end
    chk("Busy",      64'(bus.Busy),      64'(m_active));
    chk("Done",      64'(bus.Done),      64'(e_done));
    chk("CaptureDR", 64'(bus.CaptureDR), 64'(e_cap));
    chk("ShiftDR",   64'(bus.ShiftDR),   64'(e_sh));
    chk("UpdateDR",  64'(bus.UpdateDR),  64'(e_upd));
    chk("Select",    64'(bus.Select),    64'(e_sel));
    chk("RdData",    bus.RdData,         e_rd);
    if (e_sh)
      chk("ScanIn", 64'(bus.ScanIn), (m_wr >> (m_t - 2)) & 64'd1);
  end

  // Launches one pass from a negedge and observes it cycle by cycle
  task automatic run_pass(input int ch, input logic [63:0] wr, input logic [63:0] cv,
                          input bit nou, input int extra_start,
                          output int done_at, output int n_c, output int n_s,
                          output int n_u, output int n_d, output bit sel_ok);
    cap_val[ch]  = cv & mask(len_of(ch));
    bus.ChainSel = 2'(ch);
    bus.WrData   = wr;
`ifdef SCAN_SKIP_UPDATE_EN
    bus.NoUpdate = nou;
`endif
    bus.Start    = 1'b1;
    done_at = 0; n_c = 0; n_s = 0; n_u = 0; n_d = 0; sel_ok = 1'b1;
    @(negedge TCK);
    bus.Start = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      if (c > 1) @(negedge TCK);
      if (bus.CaptureDR) n_c++;
      if (bus.ShiftDR)   n_s++;
      if (bus.UpdateDR)  n_u++;
      if (bus.Done) begin
        n_d++;
        if (done_at == 0) done_at = c;
      end
      if (bus.Select != 4'd0 && bus.Select != (4'(1) << ch)) sel_ok = 1'b0;
      bus.Start = (c == extra_start);
      if (done_at != 0 && c >= done_at + 3) break;
    end
    bus.Start = 1'b0;
    if (done_at == 0) chk("pass_timeout", 64'd0, 64'd1);
  endtask

  int          d_at, nc, ns, nu, nd;
  bit          sok;
  logic [63:0] saved, wr_r, cv_r;
  int          ch_r, ex_r;
  bit          nou_r;

  initial begin
    Reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.ChainSel = 2'd0;
    bus.WrData   = 64'd0;
`ifdef SCAN_SKIP_UPDATE_EN
    bus.NoUpdate = 1'b0;
`endif
    @(negedge TCK);
    chk("rst_Busy",   64'(bus.Busy),   64'd0);
    chk("rst_Select", 64'(bus.Select), 64'd0);
    chk("rst_RdData", bus.RdData,      64'd0);
    chk("rst_Done",   64'(bus.Done),   64'd0);
    repeat (2) @(negedge TCK);
    #2 Reset = 1'b0;
    @(negedge TCK);

    // SW readback
    run_pass(0, 64'd0, 64'h2A5C3, 1'b0, 0, d_at, nc, ns, nu, nd, sok);
    chk("sw_done_at", 64'(d_at), 64'd21);
    chk("sw_ncap",    64'(nc),   64'd1);
    chk("sw_nshift",  64'(ns),   64'd18);
    chk("sw_nupd",    64'(nu),   64'd1);
    chk("sw_rd",      bus.RdData, 64'h2A5C3);
    chk("sw_sel",     64'(sok),  64'd1);

    // KEY force
    run_pass(1, 64'hA, 64'h5, 1'b0, 0, d_at, nc, ns, nu, nd, sok);
    chk("key_done_at", 64'(d_at),  64'd7);
    chk("key_upd",     upd[1],     64'hA);
    chk("key_rd",      bus.RdData, 64'h5);

    // HEX maximum length, looped back
    run_pass(3, 64'h00A5A55A5A0F0FF0, 64'h00A5A55A5A0F0FF0, 1'b0, 0, d_at, nc, ns, nu, nd, sok);
    chk("hex_nshift", 64'(ns),          64'd56);
    chk("hex_rd",     bus.RdData,       64'h00A5A55A5A0F0FF0);
    chk("hex_upper",  64'(bus.RdData[63:56]), 64'd0);
    chk("hex_upd",    upd[3],           64'h00A5A55A5A0F0FF0);

    // Start while busy on LED
    run_pass(2, 64'h5A5A5A5, 64'h3C3C3C3, 1'b0, 5, d_at, nc, ns, nu, nd, sok);
    chk("led_done_at", 64'(d_at), 64'd30);
    chk("led_ndone",   64'(nd),   64'd1);
    chk("led_sel",     64'(sok),  64'd1);

    // Reset at shift bit 10 of an SW scan
    cap_val[0]   = 64'h1234 & mask(18);
    bus.ChainSel = 2'd0;
    bus.WrData   = 64'h3FFFF;
    bus.Start    = 1'b1;
    @(negedge TCK);
    bus.Start = 1'b0;
    repeat (11) @(negedge TCK);
    #2 Reset = 1'b1;
    #1;
    chk("rstmid_Busy",    64'(bus.Busy),    64'd0);
    chk("rstmid_Select",  64'(bus.Select),  64'd0);
    chk("rstmid_ShiftDR", 64'(bus.ShiftDR), 64'd0);
    @(negedge TCK);
    #2 Reset = 1'b0;
    nu = 0; nd = 0;
    repeat (25) begin
      @(negedge TCK);
      if (bus.UpdateDR) nu++;
      if (bus.Done)     nd++;
    end
    chk("rstmid_noupd",  64'(nu), 64'd0);
    chk("rstmid_nodone", 64'(nd), 64'd0);
    run_pass(0, 64'h15555, 64'h2A5C3, 1'b0, 0, d_at, nc, ns, nu, nd, sok);
    chk("rstmid_again_done_at", 64'(d_at), 64'd21);
    chk("rstmid_again_rd",      bus.RdData, 64'h2A5C3);

`ifdef SCAN_SKIP_UPDATE_EN
    saved = upd[2];
    run_pass(2, 64'h7FFFFFF, 64'h1234567, 1'b1, 0, d_at, nc, ns, nu, nd, sok);
    chk("skip_done_at", 64'(d_at), 64'd29);
    chk("skip_nupd",    64'(nu),   64'd0);
    chk("skip_hold",    upd[2],    saved);
`endif

    // Randomized passes
    for (int p = 0; p < 40; p++) begin
      ch_r  = int'($urandom_range(0, 3));
      wr_r  = {$urandom, $urandom};
      cv_r  = {$urandom, $urandom};
`ifdef SCAN_SKIP_UPDATE_EN
      nou_r = 1'($urandom_range(0, 1));
`else
      nou_r = 1'b0;
`endif
      ex_r  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len_of(ch_r) + 1)) : 0;
      saved = upd[ch_r];
      run_pass(ch_r, wr_r, cv_r, nou_r, ex_r, d_at, nc, ns, nu, nd, sok);
      chk("rnd_done_at", 64'(d_at), 64'(nou_r ? len_of(ch_r) + 2 : len_of(ch_r) + 3));
      chk("rnd_ndone",   64'(nd),   64'd1);
      chk("rnd_rd",      bus.RdData, cv_r & mask(len_of(ch_r)));
      chk("rnd_upd",     upd[ch_r], nou_r ? saved : (wr_r & mask(len_of(ch_r))));
      repeat ($urandom_range(0, 3)) @(negedge TCK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
